// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage control and the iterative
// RV32M divider. The pipeline side is the master, the divider the slave.
interface div_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic         kill;
    logic [1:0]   op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, kill, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring,
// one quotient bit per clock. Divide-by-zero and signed overflow are
// resolved at accept and finish in a single cycle. busy, done and result
// are all registered.
module div_unit #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvsr_q, dvsr_d;
    logic [1:0]    op_q, op_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic [N-1:0]  result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Accept-side decode: operand signs, magnitudes and special divisors.
    // op[0]=0 selects the signed flavours (DIV/REM).
    logic         signed_op_s;
    logic         a_neg_s, b_neg_s;
    logic [N-1:0] a_mag_s, b_mag_s;
    logic         div_zero_s, ovf_s, special_s;
    logic [N-1:0] spec_q_s, spec_r_s, spec_res_s;

    assign signed_op_s = ~bus.op[0];
    assign a_neg_s     = signed_op_s & bus.dividend[N-1];
    assign b_neg_s     = signed_op_s & bus.divisor[N-1];
    // |MIN| wraps back to MIN, which is correct read as unsigned.
    assign a_mag_s     = a_neg_s ? -bus.dividend : bus.dividend;
    assign b_mag_s     = b_neg_s ? -bus.divisor  : bus.divisor;
    assign div_zero_s  = (bus.divisor == {N{1'b0}});
    assign ovf_s       = signed_op_s
                         & (bus.dividend == {1'b1, {(N-1){1'b0}}})
                         & (bus.divisor  == {N{1'b1}});
    assign special_s   = div_zero_s | ovf_s;
    // Both special cases leave the quotient/remainder derivable from inputs:
    // x/0 -> q=all ones, r=x ; MIN/-1 -> q=MIN, r=0.
    assign spec_q_s    = div_zero_s ? {N{1'b1}} : bus.dividend;
    assign spec_r_s    = div_zero_s ? bus.dividend : {N{1'b0}};
    assign spec_res_s  = bus.op[1] ? spec_r_s : spec_q_s;

    // One restoring step: shift {rem,quo} left, trial-subtract at N+1 bits.
    // rem < divisor before the shift, so the trial never exceeds N+1 bits.
    logic [N:0]   shift_s, trial_s;
    logic [N-1:0] rem_nx_s, quo_nx_s;
    logic [N-1:0] q_fix_s, r_fix_s, fix_res_s;

    assign shift_s   = {rem_q, quo_q[N-1]};
    assign trial_s   = shift_s - {1'b0, dvsr_q};
    assign rem_nx_s  = trial_s[N] ? shift_s[N-1:0] : trial_s[N-1:0];
    assign quo_nx_s  = {quo_q[N-2:0], ~trial_s[N]};
    // Sign fix-up on the final step: quotient negated on differing signs,
    // remainder follows the dividend's sign.
    assign q_fix_s   = negq_q ? -quo_nx_s : quo_nx_s;
    assign r_fix_s   = negr_q ? -rem_nx_s : rem_nx_s;
    assign fix_res_s = op_q[1] ? r_fix_s : q_fix_s;

    // Next-state and datapath update; kill overrides everything else.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        op_d     = op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;

        if (bus.kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_d = bus.op;
                        if (special_s) begin
                            result_d = spec_res_s;
                            state_d  = S_DONE;
                        end else begin
                            cnt_d   = CW'(N);
                            rem_d   = {N{1'b0}};
                            quo_d   = a_mag_s;
                            dvsr_d  = b_mag_s;
                            negq_d  = a_neg_s ^ b_neg_s;
                            negr_d  = a_neg_s;
                            state_d = S_BUSY;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    rem_d = rem_nx_s;
                    quo_d = quo_nx_s;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d = fix_res_s;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered outputs; asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            rem_q    <= {N{1'b0}};
            quo_q    <= {N{1'b0}};
            dvsr_q   <= {N{1'b0}};
            op_q     <= 2'b00;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= {N{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            op_q     <= op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks for div_unit against a plain-arithmetic model.
module tb_div_unit;
    localparam int N = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] last_res;

    div_unit_if #(.N(N)) bus ();

    div_unit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics from plain arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!o[0] && a == MIN && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (!o[0]) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == MIN && b == 32'hFFFF_FFFF) return 1;
        return N + 1;
    endfunction

    // Called in an IDLE cycle (#1 after an edge); returns in the IDLE cycle
    // right after done, so consecutive calls issue back-to-back starts.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bus.start = 1'b1;
        bus.op = o;
        bus.dividend = a;
        bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "-busy1"}, {31'd0, bus.busy}, 32'd1);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "-lat"}, lat, exp_lat);
        chk({tag, "-res"}, bus.result, exp);
        chk({tag, "-busydone"}, {31'd0, bus.busy}, 32'd1);
        last_res = exp;
        @(posedge clk); #1;
        chk({tag, "-idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int lat;
        int dones;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        total = 0;
        bad = 0;
        last_res = 32'd0;
        bus.start = 1'b0;
        bus.kill = 1'b0;
        bus.op = 2'b00;
        bus.dividend = 32'd0;
        bus.divisor = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst-busy", {31'd0, bus.busy}, 32'd0);
        chk("rst-done", {31'd0, bus.done}, 32'd0);
        chk("rst-res", bus.result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("divu100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("div-7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem-7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("rem7_-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divovf", 2'b00, MIN, 32'hFFFF_FFFF, MIN, 1);
        run_op("removf", 2'b10, MIN, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1);
        run_op("div-5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem-5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run_op("divmin_1", 2'b00, MIN, 32'd1, MIN, 33);

        // Kill at BUSY cycle 10: idle next edge, no done, result kept.
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        chk("kill-busy", {31'd0, bus.busy}, 32'd0);
        chk("kill-done", {31'd0, bus.done}, 32'd0);
        chk("kill-res", bus.result, last_res);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        chk("kill-nodone", dones, 0);

        // Start while busy is ignored and not queued.
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.dividend = 32'd9;
        bus.divisor = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 6;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ign-lat", lat, 33);
        chk("ign-res", bus.result, 32'd333);
        last_res = 32'd333;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1 || bus.done === 1'b1) dones++;
        end
        chk("ign-noqueue", dones, 0);

        // Reset mid-BUSY clears outputs without waiting for a clock.
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.dividend = 32'd77;
        bus.divisor = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst-busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst-done", {31'd0, bus.done}, 32'd0);
        chk("mrst-res", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random back-to-back operations with a mix of corner operands.
        for (int i = 0; i < 1500; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = MIN;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op("rnd", o, a, b, ref_res(o, a, b), ref_lat(o, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
